// File: rtl/cordiv_sched_pkg.sv
// Shared types, constants and the LFSR step function for the correlated-divider
// job scheduler.
package cordiv_sched_pkg;

  localparam int CS_WIDTH = 8;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 (maximal length, never reaches zero)
  localparam logic [CS_WIDTH-1:0] CS_LFSR_TAPS = 8'hB8;
  localparam logic [CS_WIDTH-1:0] CS_SEED_A    = 8'h5A;
  localparam logic [CS_WIDTH-1:0] CS_SEED_B    = 8'hC3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } cordiv_sched_state_e;

  function automatic logic [CS_WIDTH-1:0] lfsr_step(input logic [CS_WIDTH-1:0] cur);
    return {cur[CS_WIDTH-2:0], ^(cur & CS_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cordiv_sched_if.sv
// Request/response handshakes plus the bitstream controls towards the divider.
// slave is the scheduler side, master is the host + divider side.
interface cordiv_sched_if #(
  parameter int LEN = 256
);
  import cordiv_sched_pkg::*;

  localparam int QW = $clog2(LEN + 1);

  logic                req_valid;
  logic                req_ready;
  logic [CS_WIDTH-1:0] req_dividend;
  logic [CS_WIDTH-1:0] req_divisor;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [QW-1:0]       rsp_quotient;
  logic                rsp_divzero;
  logic                dp_dividend;
  logic                dp_divisor;
  logic [CS_WIDTH-1:0] dp_randnum;
  logic                dp_sel;
  logic                dp_quotient;

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready, dp_quotient,
    output req_ready, rsp_valid, rsp_quotient, rsp_divzero,
           dp_dividend, dp_divisor, dp_randnum, dp_sel
  );

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready, dp_quotient,
    input  req_ready, rsp_valid, rsp_quotient, rsp_divzero,
           dp_dividend, dp_divisor, dp_randnum, dp_sel
  );

endinterface

// File: rtl/cordiv_sched_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous reload and step enable.
module lfsr8
  import cordiv_sched_pkg::*;
#(
  parameter logic [CS_WIDTH-1:0] RST_SEED = CS_SEED_A
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CS_WIDTH-1:0] seed,
  input  logic                en,
  output logic [CS_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_SEED;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/cordiv_sched.sv
// Job scheduler for the stochastic correlated divider: streams operands, counts
// quotient ones over LEN cycles. Define CORDIV_SCHED_DIVZERO_EN to short-circuit zero divisors.
//
// state | meaning
// IDLE  | req_ready high, waiting for a job
// WARM  | streams running, divider settling, nothing counted
// RUN   | streams running, quotient ones counted
// DONE  | result held on rsp_* until rsp_ready
module cordiv_sched
  import cordiv_sched_pkg::*;
#(
  parameter int                  LEN    = 256,
  parameter int                  WARMUP = 16,
  parameter logic [CS_WIDTH-1:0] SEED_A = CS_SEED_A,
  parameter logic [CS_WIDTH-1:0] SEED_B = CS_SEED_B
) (
  input  logic           clk,
  input  logic           rst,
  cordiv_sched_if.slave  bus
);

  localparam int QW      = $clog2(LEN + 1);
  localparam int CNT_MAX = (LEN > WARMUP) ? LEN : WARMUP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] WARM_LOAD = CW'(WARMUP - 1);
  localparam logic [CW-1:0] RUN_LOAD  = CW'(LEN - 1);
  localparam logic [QW-1:0] DZ_RESULT = QW'(LEN);

  cordiv_sched_state_e state_q;
  cordiv_sched_state_e state_d;

  logic [CW-1:0]       cnt_q;
  logic [QW-1:0]       ones_cnt;
  logic [CS_WIDTH-1:0] dividend_q;
  logic [CS_WIDTH-1:0] divisor_q;
  logic [CS_WIDTH-1:0] lfsr_a;
  logic [CS_WIDTH-1:0] lfsr_b;

  logic req_ready_c;
  logic rsp_valid_c;
  logic stream_en;
  logic count_en;
  logic accept;
  logic zero_div;

`ifdef CORDIV_SCHED_DIVZERO_EN
  assign zero_div = (bus.req_divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  assign accept = req_ready_c & bus.req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) state_d = zero_div ? ST_DONE : ST_WARM;
      ST_WARM: if (cnt_q == '0) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    stream_en   = 1'b0;
    count_en    = 1'b0;
    case (state_q)
      ST_IDLE: req_ready_c = 1'b1;
      ST_WARM: stream_en   = 1'b1;
      ST_RUN: begin
        stream_en = 1'b1;
        count_en  = 1'b1;
      end
      ST_DONE: rsp_valid_c = 1'b1;
      default: ;
    endcase
  end

  // One down-counter serves both phases: reload for RUN on WARM terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      ones_cnt   <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else if (accept) begin
      cnt_q      <= WARM_LOAD;
      ones_cnt   <= zero_div ? DZ_RESULT : '0;
      dividend_q <= bus.req_dividend;
      divisor_q  <= bus.req_divisor;
    end else if (stream_en) begin
      if (cnt_q == '0) begin
        cnt_q <= RUN_LOAD;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (count_en) begin
        ones_cnt <= ones_cnt + QW'(bus.dp_quotient);
      end
    end
  end

`ifdef CORDIV_SCHED_DIVZERO_EN
  logic divzero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divzero_q <= 1'b0;
    end else if (accept) begin
      divzero_q <= zero_div;
    end
  end

  assign bus.rsp_divzero = divzero_q;
`else
  assign bus.rsp_divzero = 1'b0;
`endif

  lfsr8 #(.RST_SEED(SEED_A)) u_lfsr_a (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .seed (SEED_A),
    .en   (stream_en),
    .q    (lfsr_a)
  );

  lfsr8 #(.RST_SEED(SEED_B)) u_lfsr_b (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .seed (SEED_B),
    .en   (stream_en),
    .q    (lfsr_b)
  );

  // Both operand streams compare against the same LFSR to keep them positively correlated
  assign bus.dp_dividend  = stream_en & (dividend_q > lfsr_a);
  assign bus.dp_divisor   = stream_en & (divisor_q > lfsr_a);
  assign bus.dp_sel       = stream_en & (lfsr_a[0] ^ lfsr_b[0]);
  assign bus.dp_randnum   = lfsr_b;

  assign bus.req_ready    = req_ready_c;
  assign bus.rsp_valid    = rsp_valid_c;
  assign bus.rsp_quotient = ones_cnt;

endmodule

// File: tb/tb_cordiv_sched.sv
// Scoreboard bench for cordiv_sched: a behavioural divider drives dp_quotient, a
// reference model predicts every response, a negedge monitor compares.
`timescale 1ns/1ps
module tb_cordiv_sched;

  localparam int LEN     = 256;
  localparam int WARMUP  = 16;
  localparam int JOB_LAT = WARMUP + LEN + 1;

  typedef struct {
    int quot;
    int lat;
    int dz;
    int acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic div_rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_q = 0;
  exp_t sbq[$];
  logic [7:0] m_buf = 8'h55;

  cordiv_sched_if #(.LEN(LEN)) bus ();

  cordiv_sched #(
    .LEN    (LEN),
    .WARMUP (WARMUP),
    .SEED_A (8'h5A),
    .SEED_B (8'hC3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: divisor 1 passes the dividend bit and stores it in an
  // 8-entry shuffle buffer; divisor 0 replays a stored bit chosen by sel/randnum.
  logic [7:0] dbuf;
  logic [2:0] didx;
  assign didx = {bus.dp_sel, bus.dp_randnum[1:0]};
  assign bus.dp_quotient = bus.dp_divisor ? bus.dp_dividend : dbuf[didx];
  always @(posedge clk) begin
    if (div_rst) dbuf <= 8'h55;
    else if (bus.dp_divisor) dbuf[didx] <= bus.dp_dividend;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Predicts one job from the stream rules, carrying the divider buffer across jobs
  task automatic model_job(input int dvd, input int dvs, output exp_t e);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] bf;
    logic       pa;
    logic       pb;
    logic       q;
    int         idx;
    int         ones;
    e.dz  = 0;
    e.lat = JOB_LAT;
    e.quot = 0;
    e.acc_cyc = 0;
`ifdef CORDIV_SCHED_DIVZERO_EN
    if (dvs == 0) begin
      e.dz   = 1;
      e.lat  = 1;
      e.quot = LEN;
    end else begin
`else
    begin
`endif
      a = 8'h5A;
      b = 8'hC3;
      bf = m_buf;
      ones = 0;
      for (int k = 0; k < WARMUP + LEN; k++) begin
        pa  = (dvd > int'(a));
        pb  = (dvs > int'(a));
        idx = int'({a[0] ^ b[0], b[1:0]});
        q   = pb ? pa : bf[idx];
        if (k >= WARMUP) ones += int'(q);
        if (pb) bf[idx] = pa;
        a = lfsr_next(a);
        b = lfsr_next(b);
      end
      m_buf  = bf;
      e.quot = ones;
    end
  endtask

  // Returns at the negedge following the accept edge
  task automatic issue(input int dvd, input int dvs, input bit expect_rsp);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    bus.req_dividend = 8'(dvd);
    bus.req_divisor  = 8'(dvs);
    bus.req_valid    = 1'b1;
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", int'(bus.req_ready), 1);
    if (expect_rsp) begin
      model_job(dvd, dvs, e);
      e.acc_cyc = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = bus.rsp_valid;
    if (!ok) check("rsp_timeout", 0, 1);
  endtask

  task automatic release_rsp(input int delay);
    repeat (delay) @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("idle_after_rsp", int'(bus.req_ready), 1);
  endtask

  task automatic run_job(input int dvd, input int dvs, input int delay, output int quot);
    bit ok;
    issue(dvd, dvs, 1'b1);
    wait_valid(JOB_LAT + 20, ok);
    quot = last_q;
    if (ok) release_rsp(delay);
  endtask

  // Monitor: pops and compares on every rising rsp_valid, checks holding while stalled
  initial begin
    exp_t e;
    bit   prev_valid;
    int   held_q;
    int   held_dz;
    prev_valid = 1'b0;
    held_q = 0;
    held_dz = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.rsp_valid && !prev_valid) begin
          check("rsp_expected", int'(sbq.size() > 0), 1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("rsp_latency", cyc - e.acc_cyc + 1, e.lat);
            check("rsp_quotient", int'(bus.rsp_quotient), e.quot);
            check("rsp_divzero", int'(bus.rsp_divzero), e.dz);
          end
          check("rsp_excl", int'(bus.req_ready), 0);
          check("done_streams_idle", int'({bus.dp_dividend, bus.dp_divisor, bus.dp_sel}), 0);
          held_q  = int'(bus.rsp_quotient);
          held_dz = int'(bus.rsp_divzero);
          last_q  = held_q;
        end else if (bus.rsp_valid && prev_valid) begin
          check("rsp_stable_q", int'(bus.rsp_quotient), held_q);
          check("rsp_stable_dz", int'(bus.rsp_divzero), held_dz);
          check("rsp_excl_hold", int'(bus.req_ready), 0);
        end
        prev_valid = bus.rsp_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q64;
    int q;
    int dvd;
    int dvs;
    bit ok;
    bus.req_valid    = 1'b0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    div_rst = 1'b0;
    m_buf = 8'h55;
    check("rst_req_ready", int'(bus.req_ready), 1);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_quotient", int'(bus.rsp_quotient), 0);
    check("rst_divzero", int'(bus.rsp_divzero), 0);
    check("rst_dp_dividend", int'(bus.dp_dividend), 0);
    check("rst_dp_divisor", int'(bus.dp_divisor), 0);
    check("rst_dp_sel", int'(bus.dp_sel), 0);
    check("rst_dp_randnum", int'(bus.dp_randnum), 8'hC3);

    run_job(64, 128, 0, q64);
    check_range("q_64_128_window", q64, 112, 144);
    run_job(200, 200, 1, q);
    check_range("q_200_200_min", q, 240, LEN);
    run_job(250, 100, 2, q);
    check_range("q_250_100_sat", q, 240, LEN);
    run_job(77, 0, 0, q);

    // Backpressure: result held, requests ignored while DONE
    issue(30, 90, 1'b1);
    wait_valid(JOB_LAT + 20, ok);
    for (int i = 0; i < 10; i++) begin
      bus.req_valid    = (i % 2 == 0);
      bus.req_dividend = 8'($urandom_range(255, 0));
      bus.req_divisor  = 8'($urandom_range(255, 1));
      @(negedge clk);
      check("bp_req_ready", int'(bus.req_ready), 0);
    end
    bus.req_valid = 1'b0;
    release_rsp(0);
    run_job(40, 160, 0, q);

    for (int j = 0; j < 4; j++) begin
      dvd = int'($urandom_range(255, 0));
      dvs = int'($urandom_range(255, 0));
      run_job(dvd, dvs, int'($urandom_range(3, 0)), q);
    end

    // Abort at RUN cycle 100; in-flight result must vanish
    issue(64, 128, 1'b0);
    repeat (WARMUP + 100) @(negedge clk);
    rst = 1'b1;
    div_rst = 1'b1;
    #1;
    check("abort_req_ready", int'(bus.req_ready), 1);
    check("abort_rsp_valid", int'(bus.rsp_valid), 0);
    check("abort_dp_dividend", int'(bus.dp_dividend), 0);
    check("abort_dp_randnum", int'(bus.dp_randnum), 8'hC3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    div_rst = 1'b0;
    m_buf = 8'h55;
    repeat (200) @(negedge clk);
    check("abort_no_rsp", int'(bus.rsp_valid), 0);
    check("abort_idle", int'(bus.req_ready), 1);
    run_job(64, 128, 0, q);
    check("rerun_matches", q, q64);

    repeat (5) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cordiv_sched.md
# cordiv_sched

Job scheduler for the stochastic correlated-divider datapath. It accepts binary dividend/divisor operands over a valid/ready request port, generates their correlated bitstreams, drives the divider's `randnum` and `sel` controls, counts quotient ones over a fixed stream length, and returns the count over a valid/ready response port. It sits between a binary host or sequencer and one stochastic divider instance.

## Interface
Parameters:
- `LEN`, 256: RUN-phase length in cycles (bitstream length); ≥ 1.
- `WARMUP`, 16: cycles streams run before counting starts; ≥ 1. Flushes divider counter and shuffle state.
- `SEED_A`, 8'h5A: SNG LFSR seed; must be non-zero.
- `SEED_B`, 8'hC3: regeneration LFSR seed; must be non-zero.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: job request.
- `req_ready` out 1: scheduler idle and able to accept.
- `req_dividend` in 8: unsigned dividend.
- `req_divisor` in 8: unsigned divisor.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: result consumed.
- `rsp_quotient` out $clog2(LEN+1): quotient ones count.
- `rsp_divzero` out 1: divisor was zero. Only meaningful with the macro.
- `dp_dividend` out 1: dividend bitstream to the divider.
- `dp_divisor` out 1: divisor bitstream to the divider.
- `dp_randnum` out 8: divider regeneration random number.
- `dp_sel` out 1: divider select bit.
- `dp_quotient` in 1: divider quotient bitstream.

## Operation
- States: IDLE, WARM, RUN, DONE.
- IDLE:
  - `req_ready=1`.
  - On `req_valid`, latch both operands, reload both LFSRs to their seeds, clear the cycle counter and `ones_cnt`, then go to WARM.
- WARM:
  - Drive the streams for WARMUP cycles without counting, then go to RUN.
- RUN:
  - Each cycle, `ones_cnt += dp_quotient`.
  - After LEN cycles, go to DONE.
- DONE:
  - `rsp_valid=1`.
  - `rsp_quotient=ones_cnt` and `rsp_divzero` are held stable.
  - On `rsp_ready`, go to IDLE.
- LFSRs:
  - Two 8-bit Fibonacci LFSRs, polynomial x^8+x^6+x^5+x^4+1 (maximal length, period 255, never zero).
  - They advance only in WARM and RUN and hold otherwise.
- Stream generation (WARM and RUN):
  - `dp_dividend = (dividend_q > lfsr_a)` and `dp_divisor = (divisor_q > lfsr_a)`. Sharing one LFSR gives the positive correlation the divider requires.
  - `dp_randnum = lfsr_b`.
  - `dp_sel = lfsr_a[0] ^ lfsr_b[0]`.
- In IDLE and DONE: `dp_dividend`, `dp_divisor` and `dp_sel` are 0, and `dp_randnum` holds the `lfsr_b` value.
- Width rules:
  - The cycle counter is $clog2(max(LEN,WARMUP)+1) bits.
  - `ones_cnt` cannot overflow, since at most LEN ones are counted.
- Expected result: ≈ LEN·dividend/divisor when dividend ≤ divisor. The result saturates toward LEN when dividend > divisor.
- Boundaries:
  - `req_valid` is ignored outside IDLE.
  - No overlap between jobs: `req_ready` and `rsp_valid` are never both 1.
  - `rst` in any state returns immediately to IDLE and clears all state; any in-flight result is lost.
  - `rst` does not reset the divider. WARM absorbs stale divider state.

## Timing
- Reset values: `req_ready=1`, `rsp_valid=0`, `rsp_quotient=0`, `rsp_divzero=0`, `dp_dividend=0`, `dp_divisor=0`, `dp_sel=0`, `dp_randnum=SEED_B`.
- Job timeline, with the accept edge at cycle 0:
  - Streams are live from cycle 1.
  - RUN spans cycles WARMUP+1 … WARMUP+LEN.
  - `rsp_valid` rises at cycle WARMUP+LEN+1.
- On the `rsp_valid & rsp_ready` edge, the next cycle is IDLE with `req_ready=1`.
- Back-to-back jobs are spaced by WARMUP+LEN+3 cycles minimum.
- `dp_quotient` is sampled in the same RUN cycle it is presented. The divider's internal latency is covered by WARM.

## Configuration
- `CORDIV_SCHED_DIVZERO_EN` defined:
  - An accepted request with `req_divisor==0` goes directly IDLE→DONE.
  - It returns `rsp_quotient=LEN` and `rsp_divzero=1`, with `rsp_valid` at cycle 1.
  - The streams stay idle for that job.
- Macro undefined:
  - There is no zero check; a zero divisor runs the full job.
  - `rsp_divzero` is tied to 0.

## Structure
- Package `cordiv_sched_pkg` holds:
  - the state enum `cordiv_sched_state_e`;
  - `CS_WIDTH=8`;
  - the LFSR tap mask `CS_LFSR_TAPS=8'hB8`;
  - the default seeds.
- Sub-module `lfsr8`, instantiated twice. Ports: `clk`, `rst`, `load`, `seed`, `en`, `q`.

## Test plan
- Reset: hold `rst` for 3 cycles. Then `req_ready=1`, `rsp_valid=0`, all `dp_*` bit outputs are 0, and `dp_randnum=8'hC3`.
- Divide 64/128 with the default parameters, against a behavioural divider model:
  - `rsp_valid` rises exactly 273 cycles after accept.
  - `rsp_quotient` matches the model exactly and lies within 128±16.
- Divide 200/200: `rsp_quotient` ≥ 240. Divide 250/100: `rsp_quotient` ≥ 240 (saturation).
- Divisor 0:
  - With the macro: `rsp_valid` at cycle 1, `rsp_quotient=256`, `rsp_divzero=1`.
  - Without the macro: `rsp_valid` at cycle 273 and `rsp_divzero=0`.
- Backpressure:
  - Hold `rsp_ready` low for 10 cycles in DONE while pulsing `req_valid`. The result stays stable, `req_ready` stays 0, and no job is accepted.
  - Then raise `rsp_ready`. `req_ready=1` on the next cycle and the new job is accepted.
- Mid-job reset: assert `rst` at RUN cycle 100.
  - The scheduler enters IDLE immediately and `rsp_valid` stays 0.
  - Rerun 64/128 with the divider also reset. The result is identical to the 64/128 run.
